// File: rtl/ofm_drain_if.sv
// Handshake/bus bundle between the OFM drain controller, the OFM DPRAM
// port A and the downstream element stream.
interface ofm_drain_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int INOUT_WIDTH = 256,
  parameter int ADDR_WIDTH  = 14
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [INOUT_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;

  modport master (
    input  start, ram_dout, m_ready,
    output busy, done, ram_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, ram_dout, m_ready,
    input  busy, done, ram_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ofm_drain_controller.sv
// Drains packed OFM words from DPRAM port A and serialises them, lane 0 first,
// onto a valid/ready element stream with a one-word prefetch buffer.
module ofm_drain_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int INOUT_WIDTH = 256,
  parameter int ADDR_LINE   = 16384,
  parameter int ADDR_WIDTH  = $clog2(ADDR_LINE)
) (
  input  logic      clk,
  input  logic      rst,
  ofm_drain_if.master bus
);

  localparam int ELEMS  = INOUT_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(ADDR_LINE - 1);
  localparam logic [CNT_W-1:0]  LINE_C    = CNT_W'(ADDR_LINE);
  localparam logic [CNT_W-1:0]  ELEMS_C   = CNT_W'(ELEMS);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [INOUT_WIDTH-1:0] sh_q, sh_d;
  logic [INOUT_WIDTH-1:0] pf_q, pf_d;
  logic                   sh_vld_q, sh_vld_d;
  logic                   pf_vld_q, pf_vld_d;
  logic                   inflight_q, inflight_d;
  logic                   all_iss_q, all_iss_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

  logic                   hs;
  logic                   last_elem;
  logic                   final_beat;
  logic                   pop;
  logic                   issue;
  logic                   active;
  logic [1:0]             occ;
  logic [CNT_W-1:0]       addr_next;

  assign active     = (state_q == S_FILL) || (state_q == S_STREAM);
  assign hs         = sh_vld_q && bus.m_ready;
  assign last_elem  = (cnt_q == LAST_IDX);
  assign final_beat = hs && last_elem;
  assign pop        = hs && ((lane_q == LANE_LAST) || last_elem);
  assign addr_next  = CNT_W'(addr_q) + ELEMS_C;

  // Words held or owed after this edge; a new read lands two edges out, so
  // it may only be issued when at most one slot will be taken by then.
  assign occ   = 2'(sh_vld_q) + 2'(pf_vld_q) + 2'(inflight_q) - 2'(pop);
  assign issue = active && !all_iss_q && (occ <= 2'd1);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    pf_d       = pf_q;
    sh_vld_d   = sh_vld_q;
    pf_vld_d   = pf_vld_q;
    inflight_d = inflight_q;
    all_iss_d  = all_iss_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_FILL;
          addr_d     = '0;
          all_iss_d  = 1'b0;
          cnt_d      = '0;
          lane_d     = '0;
          sh_vld_d   = 1'b0;
          pf_vld_d   = 1'b0;
          inflight_d = 1'b0;
        end
      end

      S_FILL, S_STREAM: begin
        inflight_d = issue;
        if (issue) begin
          if (addr_next < LINE_C) begin
            addr_d = addr_next[ADDR_WIDTH-1:0];
          end else begin
            all_iss_d = 1'b1;
          end
        end

        if (hs) begin
          cnt_d  = cnt_q + CNT_W'(1);
          lane_d = pop ? '0 : lane_q + LANE_W'(1);
          sh_d   = sh_q >> DATA_WIDTH;
        end
        sh_vld_d = sh_vld_q && !pop;

        // Refill the shift register from prefetch first, then route read data.
        if (!sh_vld_d && pf_vld_q) begin
          sh_d     = pf_q;
          sh_vld_d = 1'b1;
          pf_vld_d = 1'b0;
        end
        if (inflight_q) begin
          if (!sh_vld_d) begin
            sh_d     = bus.ram_dout;
            sh_vld_d = 1'b1;
          end else begin
            pf_d     = bus.ram_dout;
            pf_vld_d = 1'b1;
          end
        end

        if (final_beat) begin
          state_d    = S_DONE;
          sh_vld_d   = 1'b0;
          pf_vld_d   = 1'b0;
          inflight_d = 1'b0;
          sh_d       = '0;
          pf_d       = '0;
          cnt_d      = '0;
          lane_d     = '0;
        end else if ((state_q == S_FILL) && sh_vld_d) begin
          state_d = S_STREAM;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      pf_q       <= '0;
      sh_vld_q   <= 1'b0;
      pf_vld_q   <= 1'b0;
      inflight_q <= 1'b0;
      all_iss_q  <= 1'b0;
      lane_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      pf_q       <= pf_d;
      sh_vld_q   <= sh_vld_d;
      pf_vld_q   <= pf_vld_d;
      inflight_q <= inflight_d;
      all_iss_q  <= all_iss_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.m_valid  = sh_vld_q;
  assign bus.m_data   = sh_vld_q ? sh_q[DATA_WIDTH-1:0] : '0;
  assign bus.m_last   = sh_vld_q && last_elem;
  assign bus.busy     = active;
  assign bus.done     = (state_q == S_DONE);

endmodule
